// File: rtl/inst_buffer.sv
// Instruction fetch buffer between IF and ID: captures SRAM instruction pairs,
// unpacks them into {pc, inst} entries of a circular FIFO and presents the two oldest to ID.
module inst_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [65:0]              if_to_id_bus,
    input  logic [63:0]              inst_sram_rdata,
    input  logic [1:0]               pop_num,
    output logic                     stallreq_for_fifo,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     inst0_valid,
    output logic [31:0]              inst0_pc,
    output logic [31:0]              inst0,
    output logic                     inst1_valid,
    output logic [31:0]              inst1_pc,
    output logic [31:0]              inst1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
    // Covers the pair in s1, the pair being addressed and one more issued before IF's ce_reg drops.
    localparam logic [CNT_W-1:0] STALL_MARGIN = CNT_W'(6);

    function automatic logic [1:0] min2(input logic [1:0] req, input logic [CNT_W-1:0] avail);
        logic [1:0] res;
        if (CNT_W'(req) > avail) begin
            res = avail[1:0];
        end else begin
            res = req;
        end
        return res;
    endfunction

    logic                   bus_discard_s;
    logic                   bus_ce_s;
    logic [31:0]            bus_pc_idef_s;
    logic [31:0]            bus_pc_reg_s;

    logic                   s1_valid_r;
    logic [31:0]            s1_pc_idef_r;
    logic [31:0]            s1_pc_reg_r;

    logic [63:0]            mem_r [DEPTH];
    logic [PTR_W-1:0]       head_r;
    logic [PTR_W-1:0]       tail_r;
    logic [CNT_W-1:0]       count_r;

    logic [1:0]             push_req_s;
    logic [1:0]             push_num_s;
    logic [1:0]             pop_req_s;
    logic [1:0]             pop_eff_s;
    logic [CNT_W-1:0]       free_s;
    logic [CNT_W-1:0]       count_next_s;
    logic [63:0]            wr0_data_s;
    logic [63:0]            wr1_data_s;
    logic [63:0]            rd0_s;
    logic [63:0]            rd1_s;

    assign bus_discard_s = if_to_id_bus[65];
    assign bus_ce_s      = if_to_id_bus[64];
    assign bus_pc_idef_s = if_to_id_bus[63:32];
    assign bus_pc_reg_s  = if_to_id_bus[31:0];

    // Capture stage: remembers which pair the SRAM will return next cycle.
    always_ff @(posedge clk) begin
        s1_valid_r   <= bus_ce_s & ~bus_discard_s & ~flush & ~rst;
        s1_pc_idef_r <= bus_pc_idef_s;
        s1_pc_reg_r  <= bus_pc_reg_s;
    end

    // Unpack the returned pair; an unaligned target keeps only the upper instruction.
    always_comb begin
        push_req_s = 2'd0;
        wr0_data_s = 64'd0;
        wr1_data_s = 64'd0;
        if (s1_valid_r && !flush && !rst) begin
            if (s1_pc_idef_r[2] == 1'b0) begin
                push_req_s = 2'd2;
                wr0_data_s = {s1_pc_reg_r, inst_sram_rdata[31:0]};
                wr1_data_s = {s1_pc_reg_r + 32'd4, inst_sram_rdata[63:32]};
            end else begin
                push_req_s = 2'd1;
                wr0_data_s = {s1_pc_reg_r + 32'd4, inst_sram_rdata[63:32]};
            end
        end else begin
            push_req_s = 2'd0;
        end
    end

    // Clamp pushes to free space and pops to occupancy; flush/reset cycles move nothing.
    always_comb begin
        free_s    = DEPTH_C - count_r;
        push_num_s = min2(push_req_s, free_s);
        pop_req_s = 2'd0;
        case (pop_num)
            2'd0:    pop_req_s = 2'd0;
            2'd1:    pop_req_s = 2'd1;
            2'd2:    pop_req_s = 2'd2;
            2'd3:    pop_req_s = 2'd2;
            default: pop_req_s = 2'd0;
        endcase
        if (flush || rst) begin
            pop_eff_s = 2'd0;
        end else begin
            pop_eff_s = min2(pop_req_s, count_r);
        end
        count_next_s = count_r + CNT_W'(push_num_s) - CNT_W'(pop_eff_s);
    end

    // Entry storage; contents are only observable through the valid-gated outputs.
    always_ff @(posedge clk) begin
        if (push_num_s != 2'd0) begin
            mem_r[tail_r] <= wr0_data_s;
        end
        if (push_num_s == 2'd2) begin
            mem_r[tail_r + PTR_W'(1)] <= wr1_data_s;
        end
    end

    // Pointer and occupancy state; both reset and flush empty the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + PTR_W'(pop_eff_s);
            tail_r  <= tail_r + PTR_W'(push_num_s);
            count_r <= count_next_s;
        end
    end

    // Present the two oldest entries, zeroed when not valid.
    always_comb begin
        rd0_s = mem_r[head_r];
        rd1_s = mem_r[head_r + PTR_W'(1)];
        inst0_valid = (count_r >= CNT_W'(1));
        inst1_valid = (count_r >= CNT_W'(2));
        if (inst0_valid) begin
            inst0_pc = rd0_s[63:32];
            inst0    = rd0_s[31:0];
        end else begin
            inst0_pc = 32'd0;
            inst0    = 32'd0;
        end
        if (inst1_valid) begin
            inst1_pc = rd1_s[63:32];
            inst1    = rd1_s[31:0];
        end else begin
            inst1_pc = 32'd0;
            inst1    = 32'd0;
        end
    end

    assign count             = count_r;
    assign stallreq_for_fifo = ((DEPTH_C - count_r) < STALL_MARGIN);

endmodule

// File: tb/tb_inst_buffer.sv
// Randomized scoreboard bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [65:0] if_to_id_bus = 66'd0;
    logic [63:0] inst_sram_rdata = 64'd0;
    logic [1:0]  pop_num = 2'd0;
    logic        stallreq_for_fifo;
    logic [4:0]  count;
    logic        inst0_valid, inst1_valid;
    logic [31:0] inst0_pc, inst0, inst1_pc, inst1;

    always #5 clk = ~clk;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_to_id_bus(if_to_id_bus), .inst_sram_rdata(inst_sram_rdata), .pop_num(pop_num),
        .stallreq_for_fifo(stallreq_for_fifo), .count(count),
        .inst0_valid(inst0_valid), .inst0_pc(inst0_pc), .inst0(inst0),
        .inst1_valid(inst1_valid), .inst1_pc(inst1_pc), .inst1(inst1)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] m_q [$];
    logic        m_s1v = 1'b0;
    logic [31:0] m_s1_idef = 32'd0;
    logic [31:0] m_s1_reg = 32'd0;
    logic [63:0] pend_rdata = 64'd0;
    logic        stall_d = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: occupancy is the queue size; entries are {pc, inst}.
    always @(posedge clk) begin
        logic [63:0] ent [$];
        int free;
        int npop;
        if (rst || flush) begin
            m_q.delete();
            m_s1v = 1'b0;
        end else begin
            free = DEPTH - m_q.size();
            npop = (pop_num == 2'd3) ? 2 : int'(pop_num);
            if (npop > m_q.size()) npop = m_q.size();
            ent.delete();
            if (m_s1v) begin
                if (m_s1_idef[2]) begin
                    ent.push_back({m_s1_reg + 32'd4, inst_sram_rdata[63:32]});
                end else begin
                    ent.push_back({m_s1_reg, inst_sram_rdata[31:0]});
                    ent.push_back({m_s1_reg + 32'd4, inst_sram_rdata[63:32]});
                end
            end
            repeat (npop) void'(m_q.pop_front());
            foreach (ent[i]) begin
                if (free > 0) begin
                    m_q.push_back(ent[i]);
                    free--;
                end else begin
                    miscompares++;
                    $display("FAIL no_drop: write of pc %h dropped, required free space", ent[i][63:32]);
                end
            end
            m_s1v = if_to_id_bus[64] && !if_to_id_bus[65];
        end
        m_s1_idef = if_to_id_bus[63:32];
        m_s1_reg  = if_to_id_bus[31:0];
    end

    // Monitor: compare every visible output against the model each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(m_q.size()));
            chk("stallreq", 32'(stallreq_for_fifo), 32'((DEPTH - m_q.size()) < 6));
            chk("inst0_valid", 32'(inst0_valid), 32'(m_q.size() >= 1));
            chk("inst1_valid", 32'(inst1_valid), 32'(m_q.size() >= 2));
            chk("inst0_pc", inst0_pc, (m_q.size() >= 1) ? m_q[0][63:32] : 32'd0);
            chk("inst0", inst0, (m_q.size() >= 1) ? m_q[0][31:0] : 32'd0);
            chk("inst1_pc", inst1_pc, (m_q.size() >= 2) ? m_q[1][63:32] : 32'd0);
            chk("inst1", inst1, (m_q.size() >= 2) ? m_q[1][31:0] : 32'd0);
        end
    end

    // One cycle of IF/ID stimulus; rdata for the previous address is driven now.
    task automatic step(input logic r, input logic f, input logic ce, input logic dis,
                        input logic [31:0] idef, input logic [1:0] pop, input logic [63:0] data);
        @(negedge clk);
        stall_d = stallreq_for_fifo;
        rst = r;
        flush = f;
        inst_sram_rdata = pend_rdata;
        if_to_id_bus = {dis, ce, idef, idef & 32'hffff_fff8};
        pop_num = pop;
        pend_rdata = data;
    endtask

    task automatic idle(input logic [1:0] pop);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, pop, 64'd0);
    endtask

    initial begin
        logic [31:0] pc;
        int max_cnt;
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 64'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 64'd0);
        idle(2'd0);
        mon_en = 1'b1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'({inst0_valid, inst1_valid, stallreq_for_fifo}), 32'd0);

        // First fetch: visible two cycles after the address.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0000, 2'd0, {32'h2402_0002, 32'h2401_0001});
        idle(2'd0);
        idle(2'd0);
        chk("first_inst0", inst0, 32'h2401_0001);
        chk("first_inst0_pc", inst0_pc, 32'hbfc0_0000);
        chk("first_inst1", inst1, 32'h2402_0002);
        chk("first_inst1_pc", inst1_pc, 32'hbfc0_0004);
        chk("first_count", 32'(count), 32'd2);

        // Unaligned target pushes one entry.
        idle(2'd2);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0014, 2'd0, {32'h1111_2222, 32'h3333_4444});
        idle(2'd0);
        idle(2'd0);
        chk("unal_count", 32'(count), 32'd1);
        chk("unal_pc", inst0_pc, 32'hbfc0_0014);
        chk("unal_inst", inst0, 32'h1111_2222);

        // Discarded pair never appears.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hbfc0_0020, 2'd1, 64'hdead_beef_dead_beef);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0040, 2'd0, {32'h4444_0044, 32'h4444_0040});
        idle(2'd0);
        idle(2'd0);
        chk("disc_count", 32'(count), 32'd2);
        chk("disc_inst0_pc", inst0_pc, 32'hbfc0_0040);
        chk("disc_inst1_pc", inst1_pc, 32'hbfc0_0044);

        // Push 2 and pop 1 together at count 5.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0048, 2'd0, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0054, 2'd0, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0058, 2'd0, {$urandom, $urandom});
        idle(2'd1);
        chk("pp_count5", 32'(count), 32'd5);
        idle(2'd0);
        chk("pp_count6", 32'(count), 32'd6);
        chk("pp_advance", inst0_pc, 32'hbfc0_0044);
        idle(2'd2);
        idle(2'd2);
        idle(2'd1);
        idle(2'd2);
        chk("pop2_at1_pre", 32'(count), 32'd1);
        idle(2'd0);
        chk("pop2_at1_post", 32'(count), 32'd0);

        // Fill with IF obeying a one-cycle-late stall, then drain across the wrap.
        pc = 32'hbfc0_0100;
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!stall_d) begin
                step(1'b0, 1'b0, 1'b1, 1'b0, pc, 2'd0, {$urandom, $urandom});
                pc += 32'd8;
            end else begin
                idle(2'd0);
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
        end
        idle(2'd0);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_max", 32'(max_cnt), 32'd16);
        for (int i = 0; i < 8; i++) idle(2'd2);
        idle(2'd0);
        chk("drain_count", 32'(count), 32'd0);

        // Flush with count 7, s1 valid, pop and push active.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0300, 2'd0, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0308, 2'd0, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0314, 2'd0, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0318, 2'd0, {$urandom, $urandom});
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0320, 2'd0, {$urandom, $urandom});
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'hbfc0_0328, 2'd2, {$urandom, $urandom});
        chk("preflush_count", 32'(count), 32'd7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'hbfc0_0380, 2'd0, {32'h0000_0384, 32'h0000_0380});
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valids", 32'({inst0_valid, inst1_valid}), 32'd0);
        idle(2'd0);
        idle(2'd0);
        chk("newpc_inst0_pc", inst0_pc, 32'hbfc0_0380);
        chk("newpc_inst0", inst0, 32'h0000_0380);

        // Randomized traffic.
        pc = 32'hbfc0_1000;
        for (int i = 0; i < 3000; i++) begin
            logic r, f, ce, dis, unal;
            logic [1:0] pop;
            r    = ($urandom_range(0, 299) == 0);
            f    = ($urandom_range(0, 49) == 0);
            ce   = !stall_d && ($urandom_range(0, 3) != 0);
            dis  = ($urandom_range(0, 7) == 0);
            unal = ($urandom_range(0, 5) == 0);
            pop  = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
            if (f) pc = 32'hbfc0_0000 + ($urandom_range(0, 255) << 3);
            step(r, f, ce, dis, unal ? (pc | 32'd4) : pc, pop, {$urandom, $urandom});
            if (ce) pc += 32'd8;
        end
        idle(2'd0);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
